// File: rtl/ks_mem_responder.sv
// ks_mem_responder: single-outstanding-request memory responder.
// A 32 x 16-bit register array is served through a valid/ready request
// channel and a valid/ready response channel. Each request is followed by
// WAIT_CYCLES wait states before its response is presented.
// Optional feature: define MEM_WRITE_PROTECT_EN to make the words below
// PROT_LIMIT read-only. A rejected write then responds with rsp_err=1.
module ks_mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int PROT_LIMIT  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [4:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        req_ready,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    input  logic        rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit WP_ON = 1'b1;
`else
    localparam bit WP_ON = 1'b0;
`endif

    // The counter holds the number of wait cycles still remaining after the current one.
    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit         SKIP_WAIT = (WAIT_CYCLES == 0);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic        enter_resp;

    logic        lat_write;
    logic [4:0]  lat_addr;
    logic [15:0] lat_wdata;

    logic        acc_write;
    logic [4:0]  acc_addr;
    logic [15:0] acc_wdata;
    logic        prot_hit;
    logic        write_blocked;

    logic [15:0] mem [32];

    // Next-state, counter and handshake outputs. The access operands come from
    // the live inputs when RESP is entered directly from IDLE, and from the latched copy otherwise.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        enter_resp    = 1'b0;
        req_ready     = 1'b0;
        rsp_valid     = 1'b0;
        acc_write     = lat_write;
        acc_addr      = lat_addr;
        acc_wdata     = lat_wdata;
        prot_hit      = 1'b0;
        write_blocked = 1'b0;

        case (state)
            IDLE: begin
                req_ready = 1'b1;
                acc_write = req_write;
                acc_addr  = req_addr;
                acc_wdata = req_wdata;
                if (req_valid) begin
                    if (SKIP_WAIT) begin
                        state_next = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        prot_hit      = int'(acc_addr) < PROT_LIMIT;
        write_blocked = WP_ON && acc_write && prot_hit;
    end

    // State register and wait-state counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request on accept. Later input activity is ignored until the next IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_write <= 1'b0;
            lat_addr  <= 5'd0;
            lat_wdata <= 16'd0;
        end else if (state == IDLE && req_valid) begin
            lat_write <= req_write;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
        end
    end

    // Response registers are loaded on the edge that enters RESP and held until the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 16'd0;
            rsp_err   <= 1'b0;
        end else if (enter_resp) begin
            if (acc_write) begin
                rsp_rdata <= 16'd0;
                rsp_err   <= write_blocked;
            end else begin
                rsp_rdata <= mem[acc_addr];
                rsp_err   <= 1'b0;
            end
        end
    end

    // Storage array. Writes land only on the edge entering RESP, so a reset during WAIT discards them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                mem[i] <= 16'd0;
            end
        end else if (enter_resp && acc_write && !write_blocked) begin
            mem[acc_addr] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_ks_mem_responder.sv
// Testbench for ks_mem_responder. Three instances are built with WAIT_CYCLES
// of 1, 0 and 3. Each instance is checked against directed vectors, a reset-abort
// sequence and randomized traffic, which is compared with a word-array reference model.
module tb_ks_mem_responder;

`ifdef MEM_WRITE_PROTECT_EN
    localparam bit PROT_ON = 1'b1;
`else
    localparam bit PROT_ON = 1'b0;
`endif
    localparam int PROT_LIM = 8;

    logic              clk;
    logic              rst;
    logic [2:0]        req_valid;
    logic [2:0]        req_write;
    logic [2:0][4:0]   req_addr;
    logic [2:0][15:0]  req_wdata;
    logic [2:0]        rsp_ready;
    wire  [2:0]        req_ready;
    wire  [2:0]        rsp_valid;
    wire  [2:0][15:0]  rsp_rdata;
    wire  [2:0]        rsp_err;

    int passed;
    int total;

    logic [15:0] model_mem [3][32];

    typedef struct {
        bit          wr;
        logic [4:0]  addr;
        logic [15:0] wdata;
        int          hold;
        logic [15:0] exp_rdata;
        bit          exp_err;
    } vec_t;

    vec_t vecs [10];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        ks_mem_responder #(
            .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 0 : 3)),
            .PROT_LIMIT (PROT_LIM)
        ) dut (
            .clk       (clk),
            .rst       (rst),
            .req_valid (req_valid[g]),
            .req_write (req_write[g]),
            .req_addr  (req_addr[g]),
            .req_wdata (req_wdata[g]),
            .req_ready (req_ready[g]),
            .rsp_valid (rsp_valid[g]),
            .rsp_rdata (rsp_rdata[g]),
            .rsp_err   (rsp_err[g]),
            .rsp_ready (rsp_ready[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wcOf(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic scrambleInputs(input int k);
        req_valid[k] = 1'($urandom_range(0, 1));
        req_write[k] = 1'($urandom_range(0, 1));
        req_addr[k]  = 5'($urandom);
        req_wdata[k] = 16'($urandom);
    endtask

    task automatic clearModel();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 32; a++) begin
                model_mem[k][a] = 16'd0;
            end
        end
    endtask

    // One complete transaction. Covers accept, latency, response data, the hold period and release.
    task automatic applyStimulus(input int k, input bit wr, input logic [4:0] a, input logic [15:0] wd,
                                 input int hold, input logic [15:0] er, input bit ee);
        int lat;
        @(negedge clk);
        checkOutput("req_ready_idle", 32'(req_ready[k]), 32'd1);
        req_valid[k] = 1'b1;
        req_write[k] = wr;
        req_addr[k]  = a;
        req_wdata[k] = wd;
        rsp_ready[k] = (hold == 0);
        @(posedge clk);
        #1;
        scrambleInputs(k);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!rsp_valid[k]) scrambleInputs(k);
        end while (!rsp_valid[k] && lat < 40);
        req_valid[k] = 1'b0;
        checkOutput("latency", 32'(lat), 32'(wcOf(k) + 1));
        checkOutput("rsp_rdata", 32'(rsp_rdata[k]), 32'(er));
        checkOutput("rsp_err", 32'(rsp_err[k]), 32'(ee));
        checkOutput("req_ready_busy", 32'(req_ready[k]), 32'd0);
        for (int i = 0; i < hold; i++) begin
            scrambleInputs(k);
            @(negedge clk);
            checkOutput("hold_rsp_valid", 32'(rsp_valid[k]), 32'd1);
            checkOutput("hold_rsp_rdata", 32'(rsp_rdata[k]), 32'(er));
            checkOutput("hold_rsp_err", 32'(rsp_err[k]), 32'(ee));
            checkOutput("hold_req_ready", 32'(req_ready[k]), 32'd0);
        end
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b1;
        @(negedge clk);
        rsp_ready[k] = 1'b0;
        checkOutput("rsp_valid_after", 32'(rsp_valid[k]), 32'd0);
        checkOutput("req_ready_after", 32'(req_ready[k]), 32'd1);
    endtask

    initial begin
        passed    = 0;
        total     = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = '0;
        clearModel();

        vecs[0] = '{1'b0, 5'd5,  16'h0000, 0, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 5'd20, 16'hBEEF, 0, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 5'd20, 16'h0000, 0, 16'hBEEF, 1'b0};
        vecs[3] = '{1'b1, 5'd3,  16'h1234, 0, 16'h0000, PROT_ON};
        vecs[4] = '{1'b0, 5'd3,  16'h0000, 0, PROT_ON ? 16'h0000 : 16'h1234, 1'b0};
        vecs[5] = '{1'b0, 5'd20, 16'h0000, 5, 16'hBEEF, 1'b0};
        vecs[6] = '{1'b1, 5'd31, 16'hFFFF, 2, 16'h0000, 1'b0};
        vecs[7] = '{1'b0, 5'd31, 16'h0000, 0, 16'hFFFF, 1'b0};
        vecs[8] = '{1'b1, 5'd0,  16'h0001, 0, 16'h0000, PROT_ON};
        vecs[9] = '{1'b0, 5'd0,  16'h0000, 1, PROT_ON ? 16'h0000 : 16'h0001, 1'b0};

        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("reset_req_ready", 32'(req_ready[k]), 32'd1);
            checkOutput("reset_rsp_valid", 32'(rsp_valid[k]), 32'd0);
            checkOutput("reset_rsp_rdata", 32'(rsp_rdata[k]), 32'd0);
            checkOutput("reset_rsp_err", 32'(rsp_err[k]), 32'd0);
        end
        rst = 1'b0;

        $display("[TB] directed vectors");
        for (int k = 0; k < 3; k++) begin
            for (int v = 0; v < 10; v++) begin
                applyStimulus(k, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].hold,
                              vecs[v].exp_rdata, vecs[v].exp_err);
            end
        end

        $display("[TB] reset during WAIT aborts a write");
        @(negedge clk);
        req_valid[0] = 1'b1;
        req_write[0] = 1'b1;
        req_addr[0]  = 5'd9;
        req_wdata[0] = 16'h5555;
        rsp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_rsp_valid", 32'(rsp_valid[0]), 32'd0);
        checkOutput("abort_req_ready", 32'(req_ready[0]), 32'd1);
        rst = 1'b0;
        rsp_ready[0] = 1'b0;
        clearModel();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("abort_no_response", 32'(rsp_valid[0]), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(k, 1'b0, 5'd9, 16'h0000, 0, 16'h0000, 1'b0);
            applyStimulus(k, 1'b0, 5'd20, 16'h0000, 0, 16'h0000, 1'b0);
        end

        $display("[TB] randomized traffic");
        for (int k = 0; k < 3; k++) begin
            for (int n = 0; n < 25; n++) begin
                bit          wr;
                logic [4:0]  a;
                logic [15:0] wd;
                logic [15:0] er;
                bit          ee;
                bit          blocked;
                wr = 1'($urandom_range(0, 1));
                a  = 5'($urandom);
                wd = 16'($urandom);
                if (wr) begin
                    blocked = PROT_ON && (int'(a) < PROT_LIM);
                    er = 16'h0000;
                    ee = blocked;
                    if (!blocked) model_mem[k][a] = wd;
                end else begin
                    er = model_mem[k][a];
                    ee = 1'b0;
                end
                applyStimulus(k, wr, a, wd, $urandom_range(0, 3), er, ee);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
